// File: rtl/cdce62002_spi_responder_pkg.sv
// rtl/cdce62002_spi_responder_pkg.sv - shared constants for the CDCE62002 SPI responder
package cdce62002_spi_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [3:0] ADDR_REG0   = 4'h0;
  localparam logic [3:0] ADDR_REG1   = 4'h1;
  localparam logic [3:0] ADDR_RELOAD = 4'hD;
  localparam logic [3:0] ADDR_READ   = 4'hE;
  localparam logic [3:0] ADDR_EEPROM = 4'hF;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SHIFT_IN  = 2'd1;
  localparam logic [1:0] ST_SHIFT_OUT = 2'd2;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/cdce62002_spi_responder_if.sv
// rtl/cdce62002_spi_responder_if.sv - serial configuration port between PLL programmer and target
interface cdce62002_spi_responder_if;
  logic spi_clk;
  logic spi_le;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_le, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_le, input spi_mosi, output spi_miso);
endinterface

// File: rtl/cdce62002_spi_responder_sync_edge.sv
// rtl/cdce62002_spi_responder_sync_edge.sv - 2-flop synchronizer with edge-detect flop
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/cdce62002_spi_responder.sv
// rtl/cdce62002_spi_responder.sv - CDCE62002 register-port target: LSB-first 32-bit frames,
// two RAM registers, EEPROM shadow and readback on MISO.
module cdce62002_spi_responder
  import cdce62002_spi_pkg::*;
#(
  parameter logic [31:0] RESET_REG0 = 32'h0000_0000,
  parameter logic [31:0] RESET_REG1 = 32'h0000_0001
) (
  input  logic                             clk,
  input  logic                             reset,
  cdce62002_spi_responder_if.slave         spi,
  output logic [31:0]                      reg0,
  output logic [31:0]                      reg1,
  output logic [31:0]                      eeprom0,
  output logic [31:0]                      eeprom1,
  output logic                             wr_strobe,
  output logic                             eeprom_strobe,
  output logic                             frame_error
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic le_level, le_rise, le_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  logic [1:0]  state;
  logic [5:0]  bitcnt;
  logic [31:0] shreg;
  logic [31:0] outreg;
  logic        read_pending;
  logic        read_sel;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .reset(reset), .din(spi.spi_clk),
    .sync(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_le (
    .clk(clk), .reset(reset), .din(spi.spi_le),
    .sync(le_level), .rise(le_rise), .fall(le_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi.spi_mosi),
    .sync(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic unused_levels;
  assign unused_levels = sclk_level ^ le_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bitcnt        <= 6'd0;
      shreg         <= 32'd0;
      outreg        <= 32'd0;
      read_pending  <= 1'b0;
      read_sel      <= 1'b0;
      reg0          <= RESET_REG0;
      reg1          <= RESET_REG1;
      eeprom0       <= RESET_REG0;
      eeprom1       <= RESET_REG1;
      wr_strobe     <= 1'b0;
      eeprom_strobe <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      wr_strobe     <= 1'b0;
      eeprom_strobe <= 1'b0;
      frame_error   <= 1'b0;
      // le rise wins over a coincident spi_clk edge, which is dropped
      if (le_rise) begin
        state <= ST_IDLE;
        if (state == ST_SHIFT_IN) begin
          if (bitcnt == 6'(FRAME_BITS)) begin
            case (shreg[3:0])
              ADDR_REG0: begin
                reg0      <= shreg;
                wr_strobe <= 1'b1;
              end
              ADDR_REG1: begin
                reg1      <= shreg;
                wr_strobe <= 1'b1;
              end
              ADDR_READ: begin
                read_sel     <= shreg[4];
                read_pending <= 1'b1;
              end
              ADDR_EEPROM: begin
                eeprom0       <= reg0;
                eeprom1       <= reg1;
                eeprom_strobe <= 1'b1;
              end
              ADDR_RELOAD: begin
                reg0      <= eeprom0;
                reg1      <= eeprom1;
                wr_strobe <= 1'b1;
              end
              default: ;
            endcase
          end else begin
            frame_error <= 1'b1;
          end
        end else if (state == ST_SHIFT_OUT) begin
          read_pending <= 1'b0;
        end
      end else if (le_fall) begin
        bitcnt <= 6'd0;
        shreg  <= 32'd0;
        if (read_pending) begin
          state  <= ST_SHIFT_OUT;
          outreg <= read_sel ? reg1 : reg0;
        end else begin
          state <= ST_SHIFT_IN;
        end
      end else if (state == ST_SHIFT_IN && sclk_rise) begin
        shreg  <= {mosi, shreg[31:1]};
        bitcnt <= sat_inc(bitcnt);
      end else if (state == ST_SHIFT_OUT && sclk_fall) begin
        outreg <= {1'b0, outreg[31:1]};
      end
    end
  end

  assign spi.spi_miso = (state == ST_SHIFT_OUT) & outreg[0];

endmodule

// File: tb/tb_cdce62002_spi_responder.sv
// tb/tb_cdce62002_spi_responder.sv - directed scoreboard bench for cdce62002_spi_responder
module tb_cdce62002_spi_responder;

  localparam int H = 5;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] reg0, reg1, eeprom0, eeprom1;
  logic        wr_strobe, eeprom_strobe, frame_error;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int fe_exp = 0;

  pair_t       wr_q[$];
  pair_t       ee_q[$];
  logic [31:0] miso_q[$];

  cdce62002_spi_responder_if spi_if ();

  cdce62002_spi_responder dut (
    .clk(clk),
    .reset(reset),
    .spi(spi_if),
    .reg0(reg0),
    .reg1(reg1),
    .eeprom0(eeprom0),
    .eeprom1(eeprom1),
    .wr_strobe(wr_strobe),
    .eeprom_strobe(eeprom_strobe),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every strobe pops the value the stimulus promised; an unannounced strobe meets an X expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_strobe) begin
        pair_t e;
        e = '{32'hx, 32'hx};
        if (wr_q.size() != 0) e = wr_q.pop_front();
        check("wr_strobe_regs", {reg0, reg1}, {e.a, e.b});
      end
      if (eeprom_strobe) begin
        pair_t e;
        e = '{32'hx, 32'hx};
        if (ee_q.size() != 0) e = ee_q.pop_front();
        check("eeprom_strobe_regs", {eeprom0, eeprom1}, {e.a, e.b});
      end
      if (frame_error) fe_cnt++;
    end
  end

  task automatic shift(input logic [63:0] data, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      spi_if.spi_mosi = data[i];
      spi_if.spi_clk  = 1'b0;
      repeat (H) @(posedge clk);
      @(negedge clk);
      if (i < 32) cap[i] = spi_if.spi_miso;
      spi_if.spi_clk = 1'b1;
      repeat (H) @(posedge clk);
    end
    spi_if.spi_clk = 1'b0;
  endtask

  task automatic frame(input logic [63:0] data, input int n, output logic [31:0] cap);
    spi_if.spi_le = 1'b0;
    repeat (H) @(posedge clk);
    shift(data, n, cap);
    repeat (H) @(posedge clk);
    spi_if.spi_le = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drained(input string tag);
    check({tag, "_wr_q_empty"}, 64'(wr_q.size()), 64'd0);
    check({tag, "_ee_q_empty"}, 64'(ee_q.size()), 64'd0);
    check({tag, "_frame_errors"}, 64'(fe_cnt), 64'(fe_exp));
  endtask

  initial begin
    logic [31:0] cap;
    logic [31:0] exp_miso;

    spi_if.spi_clk  = 1'b0;
    spi_if.spi_le   = 1'b1;
    spi_if.spi_mosi = 1'b0;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_regs", {reg0, reg1}, {32'h0000_0000, 32'h0000_0001});
    check("reset_eeprom", {eeprom0, eeprom1}, {32'h0000_0000, 32'h0000_0001});
    check("reset_outputs", {60'd0, spi_if.spi_miso, wr_strobe, eeprom_strobe, frame_error}, 64'd0);

    wr_q.push_back('{32'h55D0_0080, 32'h0000_0001});
    frame(64'h55D0_0080, 32, cap);
    drained("write_reg0");

    wr_q.push_back('{32'h55D0_0080, 32'h8383_E001});
    frame(64'h8383_E001, 32, cap);
    drained("write_reg1");

    ee_q.push_back('{32'h55D0_0080, 32'h8383_E001});
    frame(64'h0000_001F, 32, cap);
    drained("eeprom_store");

    frame(64'h0000_001E, 32, cap);
    drained("read_cmd");
    miso_q.push_back(32'h8383_E001);
    frame(64'h1234_5670, 32, cap);
    exp_miso = miso_q.pop_front();
    check("read_miso_reg1", {32'd0, cap}, {32'd0, exp_miso});
    check("read_ignores_mosi", {reg0, reg1}, {32'h55D0_0080, 32'h8383_E001});
    drained("read_frame");
    miso_q.push_back(32'h0000_0000);
    frame(64'h0000_0005, 32, cap);
    exp_miso = miso_q.pop_front();
    check("after_read_miso_zero", {32'd0, cap}, {32'd0, exp_miso});
    drained("unused_addr");

    fe_exp++;
    frame(64'h0000_0000, 31, cap);
    drained("short_31");
    fe_exp++;
    frame(64'h0000_0000, 33, cap);
    drained("long_33");
    fe_exp++;
    frame(64'h0000_0000, 0, cap);
    drained("zero_clock_blip");
    check("bad_frames_reg0", {32'd0, reg0}, {32'd0, 32'h55D0_0080});

    spi_if.spi_le = 1'b0;
    repeat (H) @(posedge clk);
    shift(64'h0000_0000_AAAA_0001, 16, cap);
    repeat (H) @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midframe_reset_reg1", {32'd0, reg1}, {32'd0, 32'h0000_0001});
    repeat (H) @(posedge clk);
    fe_exp++;
    shift(64'h0000_0000_0000_AAAA, 16, cap);
    repeat (H) @(posedge clk);
    spi_if.spi_le = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    drained("midframe_tail");
    check("midframe_regs", {reg0, reg1}, {32'h0000_0000, 32'h0000_0001});

    wr_q.push_back('{32'hDEAD_BEE0, 32'h0000_0001});
    frame(64'hDEAD_BEE0, 32, cap);
    drained("write_deadbee0");
    wr_q.push_back('{32'h0000_0000, 32'h0000_0001});
    frame(64'h0000_000D, 32, cap);
    drained("reload");
    check("reload_eeprom0", {32'd0, eeprom0}, {32'd0, 32'h0000_0000});
    check("idle_miso", {63'd0, spi_if.spi_miso}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdce62002_spi_responder.md
# cdce62002_spi_responder

SPI responder for the CDCE62002 register protocol: the target end of the link that the PLL programmer drives. It receives 32-bit LSB-first words framed by active-low latch enable and decodes the low nibble as a register address. It holds two writable RAM registers plus an EEPROM shadow and returns a register on MISO after a read command. It serves as the synthesizable bench model for the PLL programmer and as the CPLD-side target when the CPLD emulates the PLL configuration port.

## Interface
- RESET_REG0, 32'h0000_0000, reset/EEPROM-reload value of register 0
- RESET_REG1, 32'h0000_0001, reset/EEPROM-reload value of register 1
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- spi_clk  in  1  asynchronous serial clock; MOSI sampled on its rising edge
- spi_le  in  1  asynchronous latch enable, active low; frame = low period, word latched on rising edge
- spi_mosi  in  1  asynchronous serial data, LSB first
- spi_miso  out  1  readback data, LSB first
- reg0, reg1  out  32 each  current RAM register contents
- eeprom0, eeprom1  out  32 each  EEPROM shadow contents
- wr_strobe  out  1  one-cycle pulse when reg0/reg1 is written
- eeprom_strobe  out  1  one-cycle pulse when EEPROM shadow is updated
- frame_error  out  1  one-cycle pulse when a frame with bit count ≠ 32 is discarded

## Operation
- spi_clk, spi_le and spi_mosi each pass a 2-flop synchronizer plus a third flop for edge detection. The mosi path is delayed identically to the clock path.
- Input constraint: spi_clk high and low phases and spi_le high time ≥ 3 clk periods. Faster input is unsupported and may produce frame_error.
- States:
  - IDLE: le high.
  - SHIFT_IN: le low, receiving.
  - SHIFT_OUT: le low, read pending.
- Transitions:
  - IDLE→SHIFT_OUT on le fall if read_pending, else IDLE→SHIFT_IN.
  - Any state→IDLE on le rise.
- SHIFT_IN:
  - Each spi_clk rise shifts mosi into shreg[31] with shreg right-shifted, so the first bit ends in bit 0.
  - bitcnt (6 bits) increments and saturates at 63.
  - bitcnt and shreg clear on le fall.
- On le rise from SHIFT_IN with bitcnt==32, decode shreg[3:0]:
  - 4'h0 writes reg0 ← shreg; 4'h1 writes reg1 ← shreg; either pulses wr_strobe.
  - 4'hE is a read command: read_sel ← shreg[4], read_pending ← 1.
  - 4'hF copies reg0/reg1 → eeprom0/eeprom1 and pulses eeprom_strobe.
  - 4'hD reloads reg0/reg1 from eeprom0/eeprom1 and pulses wr_strobe.
  - All other addresses: no effect, no error.
- On le rise from SHIFT_IN with bitcnt≠32: no register change; pulse frame_error. bitcnt==0 (le blip with no clocks) is also an error.
- SHIFT_OUT:
  - On le fall, load outreg ← (read_sel ? reg1 : reg0).
  - spi_miso = outreg[0] from the cycle after le fall.
  - Each spi_clk fall shifts outreg right, filling with 0.
  - MOSI is ignored in this state.
  - On le rise, read_pending clears regardless of bit count; no frame_error.
- spi_miso = 0 outside SHIFT_OUT.

## Timing
- Reset values:
  - reg0 = RESET_REG0, reg1 = RESET_REG1, eeprom0 = RESET_REG0, eeprom1 = RESET_REG1.
  - All strobes 0, spi_miso 0, state IDLE, read_pending 0, bitcnt 0, synchronizer flops 1 for le and 0 for clk/mosi.
- Reset mid-frame abandons the frame with no write and no error pulse. Because the le synchronizer resets to 1, the low le then seen produces a fresh fall, and a partial frame follows. That frame ends in frame_error; this is the required behaviour.
- Latency, counting the first clk edge that samples a pin transition as edge 1:
  - le rise → register write and strobe visible after edge 3.
  - le fall → spi_miso valid after edge 3.
  - spi_clk fall → next miso bit after edge 3.
- Same-cycle le rise and spi_clk rise edge detections: the le rise is processed and the clock edge is discarded.
- Strobes are exactly one clk cycle wide; back-to-back frames produce separate pulses.

## Structure
- Shared package cdce62002_spi_pkg:
  - address constants ADDR_REG0, ADDR_REG1, ADDR_RELOAD, ADDR_READ, ADDR_EEPROM
  - state encoding
  - FRAME_BITS = 32
- One sub-module, sync_edge: 2-flop synchronizer plus edge flop, with parameterized reset value, sync output, rise and fall pulse outputs. It is instantiated for spi_clk, spi_le and spi_mosi; only the level output is used for mosi.

## Test plan
- Write 32'h55D0_0080, whose address nibble 0 targets reg0 → reg0 = 32'h55D0_0080, one wr_strobe pulse, reg1 unchanged, frame_error stays 0.
- Write 32'h8383_E001 (address 1) → reg1 = 32'h8383_E001. Then send 32'h0000_001F (EEPROM cmd) → eeprom1 = 32'h8383_E001 and eeprom0 = reg0, one eeprom_strobe pulse.
- Send read cmd 32'h0000_001E (sel=1), then a 32-clock frame → miso carries reg1 LSB-first, bit 0 valid before the first spi_clk rise. After le rise read_pending is 0 and a following frame returns miso 0.
- 31-bit and 33-bit frames carrying address 0 → reg0 unchanged, one frame_error pulse each. A le low pulse with zero clocks → one frame_error.
- Assert reset after 16 bits of a write to reg1 → reg1 = RESET_REG1. The remaining 16 bits then produce a frame_error and no write.
- Write reg0 = 32'hDEAD_BEE0, then send 32'h0000_000D (reload) → reg0 = eeprom0 = RESET_REG0, with one wr_strobe pulse.
